// File: rtl/hrm_iobox_pkg.sv
// Shared definitions for the HRM INBOX/OUTBOX I/O subsystem: default geometry,
// dump source selectors and bit positions inside err_flags.
package hrm_iobox_pkg;

    localparam int unsigned WIDTH_DEF  = 8;
    localparam int unsigned LGFLEN_DEF = 5;

    localparam logic DMP_INBOX  = 1'b0;
    localparam logic DMP_OUTBOX = 1'b1;

    localparam int unsigned ERR_W       = 4;
    localparam int unsigned ERR_IN_OVF  = 0;
    localparam int unsigned ERR_IN_UNF  = 1;
    localparam int unsigned ERR_OUT_OVF = 2;
    localparam int unsigned ERR_OUT_UNF = 3;

endpackage

// File: rtl/hrm_iobox_if.sv
// Host/CPU side bus of the I/O box: both FIFO ports, occupancy, dump port and error flags.
interface hrm_iobox_if
    import hrm_iobox_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned LGFLEN = LGFLEN_DEF
);
    logic              host_in_wr;
    logic [WIDTH-1:0]  host_in_data;
    logic              host_in_full;
    logic              cpu_in_rd;
    logic [WIDTH-1:0]  cpu_in_data;
    logic              cpu_in_empty;
    logic              cpu_out_wr;
    logic [WIDTH-1:0]  cpu_out_wdata;
    logic              cpu_out_full;
    logic              host_out_rd;
    logic [WIDTH-1:0]  host_out_data;
    logic              host_out_empty;
    logic [LGFLEN:0]   in_count;
    logic [LGFLEN:0]   out_count;
    logic              dmp_sel;
    logic [LGFLEN-1:0] dmp_pos;
    logic [WIDTH-1:0]  dmp_data;
    logic              dmp_valid;
    logic              err_clr;
    logic [ERR_W-1:0]  err_flags;

    modport master (
        output host_in_wr, host_in_data, cpu_in_rd, cpu_out_wr, cpu_out_wdata,
               host_out_rd, dmp_sel, dmp_pos, err_clr,
        input  host_in_full, cpu_in_data, cpu_in_empty, cpu_out_full, host_out_data,
               host_out_empty, in_count, out_count, dmp_data, dmp_valid, err_flags
    );

    modport slave (
        input  host_in_wr, host_in_data, cpu_in_rd, cpu_out_wr, cpu_out_wdata,
               host_out_rd, dmp_sel, dmp_pos, err_clr,
        output host_in_full, cpu_in_data, cpu_in_empty, cpu_out_full, host_out_data,
               host_out_empty, in_count, out_count, dmp_data, dmp_valid, err_flags
    );

endinterface

// File: rtl/hrm_iobox_dmp_fifo.sv
// FWFT FIFO with registered occupancy/flags, ovf/unf event pulses and a
// combinational random-access read port addressed relative to the head.
module hrm_iobox_dmp_fifo #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LGFLEN = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rd,
    output logic [WIDTH-1:0]  rdata_c,
    output logic              full,
    output logic              empty,
    output logic [LGFLEN:0]   count,
    output logic              ovf_c,
    output logic              unf_c,
    input  logic [LGFLEN-1:0] dmp_pos,
    output logic [WIDTH-1:0]  dmp_data_c
);
    localparam int unsigned DEPTH = 1 << LGFLEN;
    localparam int unsigned CW    = LGFLEN + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [LGFLEN-1:0] wr_ptr;
    logic [LGFLEN-1:0] rd_ptr;
    logic              rd_ok;
    logic              wr_ok;
    logic [CW-1:0]     count_nxt;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle
    always_comb begin
        rd_ok     = rd && !empty;
        wr_ok     = wr && (!full || rd_ok);
        ovf_c     = wr && !wr_ok;
        unf_c     = rd && empty;
        count_nxt = count + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + LGFLEN'(1);
            if (rd_ok) rd_ptr <= rd_ptr + LGFLEN'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_ok && !clr) mem[wr_ptr] <= wdata;
    end

    assign rdata_c    = mem[rd_ptr];
    assign dmp_data_c = mem[rd_ptr + dmp_pos];

endmodule

// File: rtl/hrm_iobox.sv
// HRM CPU I/O box: INBOX (host->CPU) and OUTBOX (CPU->host) FIFOs with a
// registered debug dump port and sticky overflow/underflow flags.
module hrm_iobox
    import hrm_iobox_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned LGFLEN = LGFLEN_DEF
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    hrm_iobox_if.slave   io
);
    logic              in_ovf;
    logic              in_unf;
    logic              out_ovf;
    logic              out_unf;
    logic [WIDTH-1:0]  in_dmp;
    logic [WIDTH-1:0]  out_dmp;
    logic [LGFLEN:0]   sel_count;
    logic [WIDTH-1:0]  sel_data;
    logic              dmp_hit;
    logic [ERR_W-1:0]  err_ev;

    hrm_iobox_dmp_fifo #(.WIDTH(WIDTH), .LGFLEN(LGFLEN)) u_inbox (
        .clk        (clk),
        .rst_n      (i_rst_n),
        .clr        (i_clr),
        .wr         (io.host_in_wr),
        .wdata      (io.host_in_data),
        .rd         (io.cpu_in_rd),
        .rdata_c    (io.cpu_in_data),
        .full       (io.host_in_full),
        .empty      (io.cpu_in_empty),
        .count      (io.in_count),
        .ovf_c      (in_ovf),
        .unf_c      (in_unf),
        .dmp_pos    (io.dmp_pos),
        .dmp_data_c (in_dmp)
    );

    hrm_iobox_dmp_fifo #(.WIDTH(WIDTH), .LGFLEN(LGFLEN)) u_outbox (
        .clk        (clk),
        .rst_n      (i_rst_n),
        .clr        (i_clr),
        .wr         (io.cpu_out_wr),
        .wdata      (io.cpu_out_wdata),
        .rd         (io.host_out_rd),
        .rdata_c    (io.host_out_data),
        .full       (io.cpu_out_full),
        .empty      (io.host_out_empty),
        .count      (io.out_count),
        .ovf_c      (out_ovf),
        .unf_c      (out_unf),
        .dmp_pos    (io.dmp_pos),
        .dmp_data_c (out_dmp)
    );

    // Dump source select and error event gathering
    always_comb begin
        sel_count = (io.dmp_sel == DMP_INBOX) ? io.in_count : io.out_count;
        sel_data  = (io.dmp_sel == DMP_INBOX) ? in_dmp : out_dmp;
        dmp_hit   = ({1'b0, io.dmp_pos} < sel_count);
        err_ev              = '0;
        err_ev[ERR_IN_OVF]  = in_ovf;
        err_ev[ERR_IN_UNF]  = in_unf;
        err_ev[ERR_OUT_OVF] = out_ovf;
        err_ev[ERR_OUT_UNF] = out_unf;
    end

    // A new event wins over a simultaneous err_clr
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            io.dmp_valid <= 1'b0;
            io.dmp_data  <= '0;
            io.err_flags <= '0;
        end else if (i_clr) begin
            io.dmp_valid <= 1'b0;
            io.dmp_data  <= '0;
            io.err_flags <= '0;
        end else begin
            io.dmp_valid <= dmp_hit;
            io.dmp_data  <= dmp_hit ? sel_data : '0;
            io.err_flags <= (io.err_clr ? '0 : io.err_flags) | err_ev;
        end
    end

endmodule

// File: tb/tb_hrm_iobox.sv
// Randomized scoreboard bench for hrm_iobox against a queue-based FIFO model.
module tb_hrm_iobox;
    localparam int unsigned W     = 8;
    localparam int unsigned LG    = 5;
    localparam int unsigned DEPTH = 32;

    typedef logic [7:0] q_t[$];

    typedef struct packed {
        logic       clr;
        logic       in_wr;
        logic [7:0] in_d;
        logic       in_rd;
        logic       out_wr;
        logic [7:0] out_d;
        logic       out_rd;
        logic       sel;
        logic [4:0] pos;
        logic       err_clr;
    } op_t;

    typedef struct packed {
        logic [5:0] ic;
        logic [5:0] oc;
        logic [7:0] ih;
        logic [7:0] oh;
        logic [3:0] err;
        logic       dv;
        logic [7:0] dd;
    } exp_t;

    logic clk = 1'b0;
    logic i_rst_n;
    logic i_clr;

    hrm_iobox_if #(.WIDTH(W), .LGFLEN(LG)) io ();

    hrm_iobox #(.WIDTH(W), .LGFLEN(LG)) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .io      (io)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    q_t   inq;
    q_t   outq;
    logic [3:0] m_err;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Queue model of one FIFO for one clock edge
    task automatic fifo_op(inout q_t q, input logic wr, input logic [7:0] d, input logic rd,
                           output logic ovf, output logic unf);
        logic rd_ok;
        logic wr_ok;
        rd_ok = rd && (q.size() > 0);
        wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
        ovf   = wr && !wr_ok;
        unf   = rd && (q.size() == 0);
        if (rd_ok) void'(q.pop_front());
        if (wr_ok) q.push_back(d);
    endtask

    // Drive one cycle of stimulus at negedge, predict post-edge state, wait a cycle
    task automatic step(input op_t o);
        exp_t e;
        logic iovf, iunf, oovf, ounf;
        int   sz;
        io.host_in_wr    = o.in_wr;
        io.host_in_data  = o.in_d;
        io.cpu_in_rd     = o.in_rd;
        io.cpu_out_wr    = o.out_wr;
        io.cpu_out_wdata = o.out_d;
        io.host_out_rd   = o.out_rd;
        io.dmp_sel       = o.sel;
        io.dmp_pos       = o.pos;
        io.err_clr       = o.err_clr;
        i_clr            = o.clr;
        e = '0;
        if (o.clr) begin
            inq.delete();
            outq.delete();
            m_err = '0;
        end else begin
            sz = o.sel ? outq.size() : inq.size();
            if (int'(o.pos) < sz) begin
                e.dv = 1'b1;
                e.dd = o.sel ? outq[o.pos] : inq[o.pos];
            end
            fifo_op(inq,  o.in_wr,  o.in_d,  o.in_rd,  iovf, iunf);
            fifo_op(outq, o.out_wr, o.out_d, o.out_rd, oovf, ounf);
            m_err = (o.err_clr ? 4'b0 : m_err) | {ounf, oovf, iunf, iovf};
        end
        e.ic  = 6'(inq.size());
        e.oc  = 6'(outq.size());
        e.ih  = (inq.size()  > 0) ? inq[0]  : 8'h00;
        e.oh  = (outq.size() > 0) ? outq[0] : 8'h00;
        e.err = m_err;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    function automatic op_t rand_op();
        op_t o;
        o         = '0;
        o.in_wr   = ($urandom_range(99) < 55);
        o.in_d    = 8'($urandom);
        o.in_rd   = ($urandom_range(99) < 45);
        o.out_wr  = ($urandom_range(99) < 55);
        o.out_d   = 8'($urandom);
        o.out_rd  = ($urandom_range(99) < 45);
        o.sel     = 1'($urandom);
        o.pos     = 5'($urandom);
        o.err_clr = ($urandom_range(99) < 4);
        o.clr     = ($urandom_range(199) == 0);
        return o;
    endfunction

    // Monitor: compare the DUT against the oldest prediction after each edge
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("in_count",       32'(io.in_count),       32'(mon_e.ic));
            chk("out_count",      32'(io.out_count),      32'(mon_e.oc));
            chk("cpu_in_empty",   32'(io.cpu_in_empty),   32'(mon_e.ic == 0));
            chk("host_in_full",   32'(io.host_in_full),   32'(mon_e.ic == 6'(DEPTH)));
            chk("host_out_empty", 32'(io.host_out_empty), 32'(mon_e.oc == 0));
            chk("cpu_out_full",   32'(io.cpu_out_full),   32'(mon_e.oc == 6'(DEPTH)));
            chk("err_flags",      32'(io.err_flags),      32'(mon_e.err));
            chk("dmp_valid",      32'(io.dmp_valid),      32'(mon_e.dv));
            chk("dmp_data",       32'(io.dmp_data),       32'(mon_e.dd));
            if (mon_e.ic != 0) chk("cpu_in_data",   32'(io.cpu_in_data),   32'(mon_e.ih));
            if (mon_e.oc != 0) chk("host_out_data", 32'(io.host_out_data), 32'(mon_e.oh));
        end
    end

    task automatic check_reset_state();
        chk("rst_in_count",  32'(io.in_count),       0);
        chk("rst_out_count", 32'(io.out_count),      0);
        chk("rst_in_empty",  32'(io.cpu_in_empty),   1);
        chk("rst_out_empty", 32'(io.host_out_empty), 1);
        chk("rst_in_full",   32'(io.host_in_full),   0);
        chk("rst_out_full",  32'(io.cpu_out_full),   0);
        chk("rst_err",       32'(io.err_flags),      0);
        chk("rst_dmp_valid", 32'(io.dmp_valid),      0);
        chk("rst_dmp_data",  32'(io.dmp_data),       0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        io.host_in_wr = 0; io.host_in_data = 0; io.cpu_in_rd = 0;
        io.cpu_out_wr = 0; io.cpu_out_wdata = 0; io.host_out_rd = 0;
        io.dmp_sel = 0; io.dmp_pos = 0; io.err_clr = 0;
        i_clr = 0; i_rst_n = 1'b1; m_err = '0;
        #2 i_rst_n = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        i_rst_n = 1'b1;

        // Basic INBOX order
        o = '0; o.in_wr = 1;
        o.in_d = 8'h11; step(o);
        o.in_d = 8'h22; step(o);
        o.in_d = 8'h33; step(o);
        o = '0; o.in_rd = 1; step(o);
        o = '0; step(o);

        // OUTBOX contents and dump window edge
        o = '0; o.out_wr = 1;
        o.out_d = 8'hA0; step(o);
        o.out_d = 8'hB1; step(o);
        o.out_d = 8'hC2; step(o);
        o = '0; o.sel = 1; o.pos = 5'd2; step(o);
        o.pos = 5'd3; step(o);

        // Fill INBOX, overflow, then push+pop while full
        while (inq.size() < DEPTH) begin
            o = '0; o.in_wr = 1; o.in_d = 8'($urandom); step(o);
        end
        o = '0; o.in_wr = 1; o.in_d = 8'h7F; step(o);
        o = '0; o.in_wr = 1; o.in_rd = 1; o.in_d = 8'h7F; step(o);
        o = '0; o.pos = 5'd31; step(o);

        // Drain, underflow, clear flags, write on empty with read
        while (inq.size() > 0) begin
            o = '0; o.in_rd = 1; o.pos = 5'($urandom); step(o);
        end
        o = '0; o.in_rd = 1; step(o);
        o = '0; o.out_rd = 1; o.in_rd = 1; step(o);
        o = '0; o.err_clr = 1; step(o);
        o = '0; o.in_rd = 1; o.err_clr = 1; step(o);
        o = '0; o.in_rd = 1; o.in_wr = 1; o.in_d = 8'h55; step(o);

        // Wrap with shallow occupancy, dump head each cycle
        for (int i = 0; i < 120; i++) begin
            o = '0; o.pos = 5'd0; o.sel = 1'b0;
            o.in_d = 8'($urandom);
            if (inq.size() <= 1)      o.in_wr = 1;
            else if (inq.size() >= 5) o.in_rd = 1;
            else begin
                o.in_wr = 1'($urandom);
                o.in_rd = 1'($urandom);
            end
            step(o);
        end

        // Soft clear wins over a simultaneous push
        o = '0; o.clr = 1; o.in_wr = 1; o.in_d = 8'h99; o.out_wr = 1; step(o);
        o = '0; step(o);

        // Random soak
        for (int i = 0; i < 800; i++) step(rand_op());

        // Async reset mid-burst at occupancy 7
        o = '0; o.clr = 1; step(o);
        o = '0; o.in_rd = 1; step(o);
        for (int i = 0; i < 7; i++) begin
            o = '0; o.in_wr = 1; o.in_d = 8'($urandom); o.out_wr = 1'($urandom);
            o.out_d = 8'($urandom); step(o);
        end
        io.host_in_wr = 0; io.cpu_in_rd = 0; io.cpu_out_wr = 0; io.host_out_rd = 0;
        io.err_clr = 0; i_clr = 0;
        #3 i_rst_n = 1'b0;
        #1 check_reset_state();
        inq.delete(); outq.delete(); m_err = '0;
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step(rand_op());

        chk("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
